// File: rtl/iommu_ds_pkg.sv
// Shared types and defaults for the IOMMU downstream read tracker.
// No logic, no latency, no flow control of its own.
// Outstanding-burst records are {id, len} in issue order.
package iommu_ds_pkg;

  localparam int unsigned DefAddrWidth   = 64;
  localparam int unsigned DefIdWidth     = 4;
  localparam int unsigned DefDepthBits   = 3;
  localparam int unsigned MaxOutstanding = 2**DefDepthBits;

  typedef struct packed {
    logic [DefIdWidth-1:0] id;
    logic [7:0]            len;
  } ds_rd_entry_t;

endpackage

// File: rtl/iommu_ds_rd_tracker_ot_fifo.sv
// Generic synchronous FIFO with a registered occupancy count.
// The head is visible while the FIFO is non-empty; a push or pop takes effect at the next edge.
// A push while full and a pop while empty are ignored.
module ds_ot_fifo #(
  parameter int unsigned DepthBits = 3,
  parameter type         entry_t   = logic [7:0]
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               push_vld,
  input  entry_t             push_dat,
  input  logic               pop_vld,
  output entry_t             head_dat,
  output logic               empty,
  output logic               full,
  output logic [DepthBits:0] count
);

  localparam int unsigned Depth = 2**DepthBits;

  entry_t               mem [Depth];
  logic [DepthBits-1:0] wr_ptr;
  logic [DepthBits-1:0] rd_ptr;
  logic                 do_push;
  logic                 do_pop;

  assign do_push  = push_vld && !full;
  assign do_pop   = pop_vld && !empty;
  assign head_dat = mem[rd_ptr];
  assign empty    = (count == '0);
  // count never exceeds Depth, so its MSB alone marks full.
  assign full     = count[DepthBits];

  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= push_dat;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/iommu_ds_rd_tracker.sv
// Issues translated reads on AR and tracks outstanding bursts in order against returning R beats.
// Latency: tr handshake -> ar_valid_o next cycle; AR handshake -> r_ready_o next cycle.
// tr_ready_o stalls on AR backpressure or when all outstanding slots are reserved; R errors are 1-cycle pulses.
module iommu_ds_rd_tracker
  import iommu_ds_pkg::*;
#(
  parameter int unsigned AddrWidth = DefAddrWidth,
  parameter int unsigned IdWidth   = DefIdWidth,
  parameter int unsigned DepthBits = DefDepthBits
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 tr_valid_i,
  output logic                 tr_ready_o,
  input  logic [AddrWidth-1:0] tr_addr_i,
  input  logic [7:0]           tr_len_i,
  input  logic [2:0]           tr_size_i,
  input  logic [IdWidth-1:0]   tr_id_i,
  output logic                 ar_valid_o,
  input  logic                 ar_ready_i,
  output logic [AddrWidth-1:0] ar_addr_o,
  output logic [7:0]           ar_len_o,
  output logic [2:0]           ar_size_o,
  output logic [IdWidth-1:0]   ar_id_o,
  input  logic                 r_valid_i,
  output logic                 r_ready_o,
  input  logic [IdWidth-1:0]   r_id_i,
  input  logic                 r_last_i,
  output logic [DepthBits:0]   outstanding_o,
  output logic                 err_unexp_r_o,
  output logic                 err_rid_o,
  output logic                 err_rlast_o
);

  localparam logic [DepthBits+1:0] Cap = {2'b01, {DepthBits{1'b0}}};

  logic                 tr_hs;
  logic                 ar_hs;
  logic                 r_hs;
  logic                 exp_last;
  logic                 pop;
  logic                 fifo_empty;
  logic                 fifo_full;
  logic [DepthBits+1:0] inflight;
  logic [8:0]           beat_cnt;
  ds_rd_entry_t         push_dat;
  ds_rd_entry_t         head;

  // A request waiting in the AR slice already owns a tracking slot.
  assign inflight   = {1'b0, outstanding_o} + {{(DepthBits+1){1'b0}}, ar_valid_o};
  assign tr_ready_o = (!ar_valid_o || ar_ready_i) && (inflight < Cap) && !fifo_full;
  assign tr_hs      = tr_valid_i && tr_ready_o;
  assign ar_hs      = ar_valid_o && ar_ready_i;

  assign push_dat.id  = ar_id_o;
  assign push_dat.len = ar_len_o;

  assign r_ready_o = !fifo_empty;
  assign r_hs      = r_valid_i && r_ready_o;
  assign exp_last  = (beat_cnt == {1'b0, head.len});
  // Completion follows the issued length, never r_last_i.
  assign pop       = r_hs && exp_last;

  ds_ot_fifo #(
    .DepthBits (DepthBits),
    .entry_t   (ds_rd_entry_t)
  ) u_ot_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push_vld (ar_hs),
    .push_dat (push_dat),
    .pop_vld  (pop),
    .head_dat (head),
    .empty    (fifo_empty),
    .full     (fifo_full),
    .count    (outstanding_o)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ar_valid_o <= 1'b0;
      ar_addr_o  <= '0;
      ar_len_o   <= '0;
      ar_size_o  <= '0;
      ar_id_o    <= '0;
    end else if (tr_hs) begin
      ar_valid_o <= 1'b1;
      ar_addr_o  <= tr_addr_i;
      ar_len_o   <= tr_len_i;
      ar_size_o  <= tr_size_i;
      ar_id_o    <= tr_id_i;
    end else if (ar_hs) begin
      ar_valid_o <= 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      beat_cnt      <= '0;
      err_unexp_r_o <= 1'b0;
      err_rid_o     <= 1'b0;
      err_rlast_o   <= 1'b0;
    end else begin
      err_unexp_r_o <= r_valid_i && fifo_empty;
      err_rid_o     <= r_hs && (r_id_i != head.id);
      err_rlast_o   <= r_hs && (r_last_i != exp_last);
      if (pop)       beat_cnt <= '0;
      else if (r_hs) beat_cnt <= beat_cnt + 1'b1;
    end
  end

endmodule
